rate_detect: RTL and testbench

//  Receive-side counterpart of the rate-code-to-divider-count mapping: observes a tick stream
//  (one pulse every Rate+1 clk cycles) and recovers the 3-bit rate code R that produced it.

---
 rtl/rate_detect.sv | 191 +++++++++++++++++++
 tb/tb_rate_detect.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_detect.sv
// rate_detect: recovers the 3-bit rate code from a periodic tick stream.
// It measures the clk-cycle interval between tick rising edges and classifies
// it against the fixed nominal period table (5..1000 cycles, +/-TOL). Lock is
// declared after LOCK_CNT consecutive matching intervals.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   tick_in    - synchronous tick stream; a rising edge is one event
//   R_det      - detected rate code, qualified by rate_valid
//   rate_valid - high while locked
//   period     - last measured interval in clk cycles
//   lock_lost  - one-cycle pulse when lock is left
//   err        - one-cycle pulse when an interval matches no table entry
module rate_detect #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned TOL      = 1,
  parameter int unsigned TIMEOUT  = 2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  output logic [2:0]       R_det,
  output logic             rate_valid,
  output logic [CNT_W-1:0] period,
  output logic             lock_lost,
  output logic             err
);

  localparam int unsigned MW = 4;
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             tick_d;
  logic             rise_c;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       cand, cand_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [MW-1:0]    inc_c;
  logic             hit_c;
  logic [2:0]       hit_code_c;
  logic [2:0]       r_det_nx;
  logic             valid_nx;
  logic [CNT_W-1:0] period_nx;
  logic             lost_nx;
  logic             err_nx;

  // Nominal tick period for each rate code
  function automatic logic [CNT_W-1:0] nominal(input logic [2:0] code);
    case (code)
      3'd0:    nominal = CNT_W'(5);
      3'd1:    nominal = CNT_W'(10);
      3'd2:    nominal = CNT_W'(25);
      3'd3:    nominal = CNT_W'(50);
      3'd4:    nominal = CNT_W'(100);
      3'd5:    nominal = CNT_W'(250);
      3'd6:    nominal = CNT_W'(500);
      default: nominal = CNT_W'(1000);
    endcase
  endfunction

  // True when |meas - nom| <= TOL
  function automatic logic near(input logic [CNT_W-1:0] meas, input logic [CNT_W-1:0] nom);
    if (meas >= nom) near = (meas - nom) <= TOL_C;
    else             near = (nom - meas) <= TOL_C;
  endfunction

  assign rise_c = tick_in & ~tick_d;

  // Interval counter: restarts at 1 on each rise, saturates at TIMEOUT
  always_comb begin
    cnt_nx = cnt;
    if (rise_c)               cnt_nx = CNT_W'(1);
    else if (cnt != TIMEOUT_C) cnt_nx = cnt + CNT_W'(1);
  end

  // Table classification of the current interval; TOL <= 2 keeps classes disjoint
  always_comb begin
    hit_c      = 1'b0;
    hit_code_c = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (near(cnt, nominal(3'(k)))) begin
        hit_c      = 1'b1;
        hit_code_c = 3'(k);
      end
    end
  end

  // Run length if this interval is accepted as a candidate match
  always_comb begin
    inc_c = MW'(1);
    if (hit_code_c == cand) inc_c = match_cnt + MW'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    match_nx  = match_cnt;
    r_det_nx  = R_det;
    valid_nx  = rate_valid;
    period_nx = period;
    lost_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        // first edge only opens the measurement window
        if (rise_c) state_nx = ACQ;
      end
      ACQ: begin
        if (rise_c) begin
          period_nx = cnt;
          if (!hit_c) begin
            match_nx = '0;
            err_nx   = 1'b1;
          end else begin
            cand_nx  = hit_code_c;
            match_nx = inc_c;
            if (inc_c >= LOCK_C) begin
              state_nx = LOCK;
              r_det_nx = hit_code_c;
              valid_nx = 1'b1;
            end
          end
        end else if (cnt == TIMEOUT_C) begin
          state_nx = IDLE;
          match_nx = '0;
        end
      end
      LOCK: begin
        if (rise_c) begin
          period_nx = cnt;
          if (!(hit_c && (hit_code_c == cand))) begin
            state_nx = ACQ;
            lost_nx  = 1'b1;
            valid_nx = 1'b0;
            if (hit_c) begin
              cand_nx  = hit_code_c;
              match_nx = MW'(1);
            end else begin
              match_nx = '0;
              err_nx   = 1'b1;
            end
          end
        end else if (cnt == TIMEOUT_C) begin
          state_nx = IDLE;
          match_nx = '0;
          lost_nx  = 1'b1;
          valid_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tick_d     <= 1'b0;
      cnt        <= '0;
      cand       <= 3'd0;
      match_cnt  <= '0;
      R_det      <= 3'd0;
      rate_valid <= 1'b0;
      period     <= '0;
      lock_lost  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      tick_d     <= tick_in;
      cnt        <= cnt_nx;
      cand       <= cand_nx;
      match_cnt  <= match_nx;
      R_det      <= r_det_nx;
      rate_valid <= valid_nx;
      period     <= period_nx;
      lock_lost  <= lost_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_rate_detect.sv
// tb_rate_detect: scoreboard bench for rate_detect. Stimulus is a sequence of
// tick intervals; an interval-level model pushes time-stamped expected events,
// and a negedge monitor compares every cycle against them.
module tb_rate_detect;

  localparam int unsigned CNT_W   = 24;
  localparam int          TIMEOUT = 2048;
  localparam int          TOL     = 1;
  localparam int          NOM [8] = '{5, 10, 25, 50, 100, 250, 500, 1000};

  logic             clk = 1'b0;
  logic             reset;
  logic             tick_in;
  logic [2:0]       R_det;
  logic             rate_valid;
  logic [CNT_W-1:0] period;
  logic             lock_lost;
  logic             err;

  always #5 clk = ~clk;

  rate_detect #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(3),
    .TOL     (TOL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .R_det     (R_det),
    .rate_valid(rate_valid),
    .period    (period),
    .lock_lost (lock_lost),
    .err       (err)
  );

  typedef struct {
    int stamp;
    int per;
    int err;
    int lost;
    int valid;
    int rdet;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // model state: m_st 0=idle 1=acquiring 2=locked
  int m_st, m_cand, m_cnt, m_valid, m_rdet, m_period;
  int prev_stamp, cur_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int classify(input int n);
    int d;
    for (int k = 0; k < 8; k++) begin
      d = (n >= NOM[k]) ? n - NOM[k] : NOM[k] - n;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cand = 0; m_cnt = 0; m_valid = 0; m_rdet = 0; m_period = 0;
    cur_w = 0; prev_stamp = 0;
  endtask

  // Issue one tick rise n cycles after the previous one and predict the outcome
  task automatic interval(input int n);
    exp_t e;
    int   w;
    int   stamp;
    int   code;
    if (m_st != 0 && n > TIMEOUT) begin
      e.stamp = prev_stamp + TIMEOUT;
      e.lost  = (m_st == 2) ? 1 : 0;
      e.err   = 0;
      m_valid = 0; m_st = 0; m_cnt = 0;
      e.per = m_period; e.valid = 0; e.rdet = m_rdet;
      q.push_back(e);
    end
    w = 1 + int'($urandom_range(0, 2));
    stamp = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      tick_in = (i == n) || (i < cur_w);
      if (i == n) stamp = cyc + 1;
    end
    cur_w = w;
    prev_stamp = stamp;
    if (m_st == 0) begin
      m_st = 1;
    end else begin
      code = classify(n);
      m_period = n;
      e.stamp = stamp; e.err = 0; e.lost = 0;
      if (m_st == 1) begin
        if (code < 0) begin
          m_cnt = 0; e.err = 1;
        end else begin
          m_cnt  = (code == m_cand) ? m_cnt + 1 : 1;
          m_cand = code;
          if (m_cnt >= 3) begin
            m_st = 2; m_valid = 1; m_rdet = code;
          end
        end
      end else if (code != m_cand) begin
        e.lost = 1; m_valid = 0; m_st = 1;
        if (code < 0) begin
          m_cnt = 0; e.err = 1;
        end else begin
          m_cand = code; m_cnt = 1;
        end
      end
      e.per = m_period; e.valid = m_valid; e.rdet = m_rdet;
      q.push_back(e);
    end
  endtask

  // Assert reset in the middle of an interval and check the asynchronous clear
  task automatic mid_reset(input int gap);
    for (int i = 1; i <= gap; i++) begin
      @(posedge clk); #1;
      tick_in = (i < cur_w);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    q.delete();
    #1;
    check("async_rst_rdet", int'(R_det), 0);
    check("async_rst_valid", int'(rate_valid), 0);
    check("async_rst_period", int'(period), 0);
    check("async_rst_lost", int'(lock_lost), 0);
    check("async_rst_err", int'(err), 0);
    tick_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Monitor: compares every cycle against held values and queued events
  initial begin
    exp_t e;
    int   h_per, h_valid, h_rdet, x_err, x_lost;
    h_per = 0; h_valid = 0; h_rdet = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_rdet", int'(R_det), 0);
        check("rst_valid", int'(rate_valid), 0);
        check("rst_period", int'(period), 0);
        check("rst_lost", int'(lock_lost), 0);
        check("rst_err", int'(err), 0);
        h_per = 0; h_valid = 0; h_rdet = 0;
      end else begin
        x_err = 0; x_lost = 0;
        while (q.size() > 0 && q[0].stamp < cyc) begin
          e = q.pop_front();
          check("event_order", cyc, e.stamp);
        end
        if (q.size() > 0 && q[0].stamp == cyc) begin
          e = q.pop_front();
          h_per = e.per; h_valid = e.valid; h_rdet = e.rdet;
          x_err = e.err; x_lost = e.lost;
        end
        check("period", int'(period), h_per);
        check("rate_valid", int'(rate_valid), h_valid);
        if (h_valid != 0) check("R_det", int'(R_det), h_rdet);
        check("err", int'(err), x_err);
        check("lock_lost", int'(lock_lost), x_lost);
      end
    end
  end

  // Stimulus
  initial begin
    int c, len, n, r;
    reset   = 1'b0;
    tick_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // steady 5-cycle ticks lock to code 0
    interval(3);
    repeat (6) interval(5);
    // 1000-cycle ticks, tolerance edges, then out of tolerance
    repeat (3) interval(1000);
    interval(1001);
    interval(999);
    interval(1002);
    // rate change 10 -> 25
    repeat (4) interval(10);
    repeat (4) interval(25);
    // loss of ticks while locked, then relock
    repeat (4) interval(50);
    interval(3000);
    repeat (4) interval(50);
    // rise coincident with timeout is an unmatched interval
    repeat (3) interval(100);
    interval(TIMEOUT);
    // alternating rates never lock; 7 is unmatched
    repeat (6) begin
      interval(5);
      interval(10);
    end
    interval(7);

    // randomized runs of jittered nominal periods and arbitrary gaps
    repeat (30) begin
      r   = int'($urandom_range(0, 9));
      c   = int'($urandom_range(0, 7));
      len = 1 + int'($urandom_range(0, 4));
      repeat (len) begin
        if (r < 8)       n = NOM[c] + int'($urandom_range(0, 4)) - 2;
        else if (r == 8) n = int'($urandom_range(4, 300));
        else             n = int'($urandom_range(2040, 2060));
        if (n < 4) n = 4;
        interval(n);
      end
    end

    // reset while locked mid-interval, then power-up behaviour again
    repeat (4) interval(50);
    mid_reset(20);
    interval(3);
    repeat (6) interval(5);

    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      tick_in = (i < cur_w);
    end
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
